instruction_fetch_unit: RTL and testbench

- Fetch stage feeding the opcode decoder/control unit of the 16-bit pipelined processor.
- Drives PC into synchronous instruction memory (1-cycle read latency) and presents 24-bit instructions to decode with a valid/stall handshake.
- Absorbs decode stalls with a 1-entry skid buffer, redirects on branch/jump from execute, pre-flags branch opcodes, and counts instructions accepted by decode.

---
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives synchronous instruction memory, tracks the in-flight read,
// and presents instructions to decode through a registered output plus a 1-entry skid.
module instruction_fetch_unit #(
  parameter int          INSTRUCTIONWIDTH = 24,
  parameter int          OPCODEWIDTH      = 4,
  parameter int          PCWIDTH          = 8,
  parameter int unsigned RESETPC          = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [PCWIDTH-1:0]          imemAddr,
  output logic                        imemRdEn,
  input  logic [INSTRUCTIONWIDTH-1:0] imemData,
  input  logic                        stallD,
  input  logic                        redirectE,
  input  logic [PCWIDTH-1:0]          redirectTargetE,
  output logic [INSTRUCTIONWIDTH-1:0] instrD,
  output logic [PCWIDTH-1:0]          pcD,
  output logic                        validD,
  output logic                        isBranchD,
  output logic [15:0]                 issuedCount
);

  localparam logic [PCWIDTH-1:0] RESET_ADDR = PCWIDTH'(RESETPC);

  logic [PCWIDTH-1:0]          pcF;
  logic                        respValid;
  logic [PCWIDTH-1:0]          respPc;
  logic                        skidValid;
  logic [INSTRUCTIONWIDTH-1:0] skidInstr;
  logic [PCWIDTH-1:0]          skidPc;
  logic [OPCODEWIDTH-1:0]      opcode;
  logic                        accept;

  assign imemAddr = redirectE ? redirectTargetE : pcF;
  assign imemRdEn = rst_n && (!stallD || redirectE);
  assign accept   = validD && !stallD && !redirectE;

  // Reads are suppressed during stall, so at most one response is ever in flight
  // when the stall begins; that is what keeps a single skid entry sufficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcF       <= RESET_ADDR;
      respValid <= 1'b0;
      respPc    <= '0;
    end else begin
      respValid <= imemRdEn;
      if (imemRdEn) begin
        respPc <= imemAddr;
        pcF    <= imemAddr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validD    <= 1'b0;
      instrD    <= '0;
      pcD       <= '0;
      skidValid <= 1'b0;
      skidInstr <= '0;
      skidPc    <= '0;
    end else if (redirectE) begin
      // The response arriving now belongs to the wrong path; simply ignore it.
      validD    <= 1'b0;
      skidValid <= 1'b0;
    end else if (stallD) begin
      if (respValid) begin
        skidValid <= 1'b1;
        skidInstr <= imemData;
        skidPc    <= respPc;
      end
    end else if (skidValid) begin
      instrD    <= skidInstr;
      pcD       <= skidPc;
      validD    <= 1'b1;
      // Refill the skid in the same edge so a concurrent response keeps its order.
      skidValid <= respValid;
      if (respValid) begin
        skidInstr <= imemData;
        skidPc    <= respPc;
      end
    end else if (respValid) begin
      instrD <= imemData;
      pcD    <= respPc;
      validD <= 1'b1;
    end else begin
      validD <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      issuedCount <= '0;
    else if (accept && issuedCount != 16'hFFFF)
      issuedCount <= issuedCount + 16'd1;
  end

  assign opcode    = instrD[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
  assign isBranchD = validD && (opcode == OPCODEWIDTH'(11) || opcode == OPCODEWIDTH'(12) ||
                                opcode == OPCODEWIDTH'(13) || opcode == OPCODEWIDTH'(15));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed stimulus with a scoreboard of expected
// accepted instructions, popped by an independent monitor on every decode acceptance.
module tb_instruction_fetch_unit;
  localparam int IW = 24;
  localparam int PW = 8;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
    logic          br;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stallD = 1'b0;
  logic          redirectE = 1'b0;
  logic [PW-1:0] redirectTargetE = '0;

  logic [PW-1:0] imemAddr, imemAddr2;
  logic          imemRdEn, imemRdEn2;
  logic [IW-1:0] imemData = '0, imemData2 = '0;
  logic [IW-1:0] instrD, instrD2;
  logic [PW-1:0] pcD, pcD2;
  logic          validD, validD2, isBranchD, isBranchD2;
  logic [15:0]   issuedCount, issuedCount2;

  logic [IW-1:0] mem [256];
  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.INSTRUCTIONWIDTH(IW), .OPCODEWIDTH(4), .PCWIDTH(PW), .RESETPC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemRdEn(imemRdEn), .imemData(imemData),
    .stallD(stallD), .redirectE(redirectE), .redirectTargetE(redirectTargetE),
    .instrD(instrD), .pcD(pcD), .validD(validD), .isBranchD(isBranchD), .issuedCount(issuedCount)
  );

  instruction_fetch_unit #(.INSTRUCTIONWIDTH(IW), .OPCODEWIDTH(4), .PCWIDTH(PW), .RESETPC(254)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr2), .imemRdEn(imemRdEn2), .imemData(imemData2),
    .stallD(stallD), .redirectE(redirectE), .redirectTargetE(redirectTargetE),
    .instrD(instrD2), .pcD(pcD2), .validD(validD2), .isBranchD(isBranchD2), .issuedCount(issuedCount2)
  );

  // Synchronous instruction memories, one-cycle read latency
  always @(posedge clk) if (imemRdEn)  imemData  <= mem[imemAddr];
  always @(posedge clk) if (imemRdEn2) imemData2 <= mem[imemAddr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [PW-1:0] pc, input logic [IW-1:0] ins, input logic br);
    return {pc, ins, br};
  endfunction

  task automatic push_std(input logic [PW-1:0] pc);
    q.push_back(mk(pc, {4'h5, 20'(pc)}, 1'b0));
  endtask

  // Monitor: inputs settle at the negedge, so +2 sees what the next posedge will act on
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (!validD) begin
        chk("isbr_when_invalid", {31'b0, isBranchD}, 32'd0);
      end else if (!stallD && !redirectE) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_unexpected actual_pc=%0h required=none", pcD);
        end else begin
          mon_e = q.pop_front();
          chk("acc_pc",    {24'b0, pcD},       {24'b0, mon_e.pc});
          chk("acc_instr", {8'b0, instrD},     {8'b0, mon_e.instr});
          chk("acc_br",    {31'b0, isBranchD}, {31'b0, mon_e.br});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4'h5, 20'(i)};

    // Reset state
    nxt(2);
    chk("rst_validD", validD, 0);
    chk("rst_pcD", pcD, 0);
    chk("rst_instrD", instrD, 0);
    chk("rst_count", issuedCount, 0);
    chk("rst_rden", imemRdEn, 0);

    // Straight-line fetch after reset, wrap instance alongside
    for (int i = 0; i < 4; i++) push_std(8'(i));
    rst_n = 1'b1;
    #1;
    chk("t1_rden_first", imemRdEn, 1);
    chk("t1_addr_first", imemAddr, 0);
    chk("t5_addr_first", imemAddr2, 8'hFE);
    nxt(); chk("t1_first_edge_valid", validD, 0);
    nxt(); chk("t1_valid", validD, 1); chk("t1_pc0", pcD, 0); chk("t1_cnt0", issuedCount, 0);
           chk("t5_pc_fe", pcD2, 8'hFE);
    nxt(); chk("t1_pc1", pcD, 1); chk("t5_pc_ff", pcD2, 8'hFF);
    nxt(); chk("t1_pc2", pcD, 2); chk("t5_pc_00", pcD2, 8'h00);
    nxt(); chk("t1_pc3", pcD, 3); chk("t1_cnt3", issuedCount, 3); chk("t5_pc_01", pcD2, 8'h01);
    nxt(); chk("t1_pc4", pcD, 4); chk("t1_cnt4", issuedCount, 4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_validD", validD, 0);
    chk("rst_mid_count", issuedCount, 0);
    chk("rst_mid_rden", imemRdEn, 0);
    chk("t1_queue_drained", q.size(), 0);

    // Stall with skid, redirect, redirect during stall with skid full
    for (int i = 0; i < 5; i++) push_std(8'(i));
    push_std(8'h40);
    push_std(8'h80);
    nxt(); rst_n = 1'b1;
    nxt(3); chk("t2_pc1", pcD, 1);
    stallD = 1'b1;
    #1; chk("t2_rden_stall", imemRdEn, 0);
    nxt(); chk("t2_hold_a", pcD, 1); chk("t2_cnt_a", issuedCount, 1);
    nxt(); chk("t2_hold_b", pcD, 1); chk("t2_instr_hold", instrD, 24'h500001);
    nxt(); chk("t2_hold_c", pcD, 1); chk("t2_valid_hold", validD, 1); chk("t2_cnt_c", issuedCount, 1);
    stallD = 1'b0;
    #1; chk("t2_resume_addr", imemAddr, 3);
    nxt(); chk("t2_pc2", pcD, 2);
    nxt(); chk("t2_pc3", pcD, 3);
    nxt(); chk("t2_pc4", pcD, 4);
    nxt(); chk("t3_pc5", pcD, 5);
    redirectE = 1'b1; redirectTargetE = 8'h40;
    #1; chk("t3_redir_addr", imemAddr, 8'h40); chk("t3_redir_rden", imemRdEn, 1);
    nxt(); redirectE = 1'b0; chk("t3_bubble", validD, 0);
    #1; chk("t3_next_addr", imemAddr, 8'h41);
    nxt(); chk("t3_pc40", pcD, 8'h40); chk("t3_valid40", validD, 1);
    nxt(); chk("t3_pc41", pcD, 8'h41);
    stallD = 1'b1;
    nxt(); chk("t4_hold41", pcD, 8'h41);
    redirectE = 1'b1; redirectTargetE = 8'h80;
    #1; chk("t4_rden_override", imemRdEn, 1);
    nxt(); stallD = 1'b0; redirectE = 1'b0; chk("t4_bubble", validD, 0);
    nxt(); chk("t4_pc80", pcD, 8'h80); chk("t4_cnt", issuedCount, 6);
    nxt(); rst_n = 1'b0;
    #1; chk("t4_queue_drained", q.size(), 0); chk("t4_rst_valid", validD, 0);

    // Branch opcode flagging
    mem[3] = 24'hB00000; mem[4] = 24'h500000; mem[5] = 24'hC00005;
    mem[6] = 24'hD00006; mem[7] = 24'hF00007; mem[8] = 24'h000008;
    for (int i = 0; i < 3; i++) push_std(8'(i));
    q.push_back(mk(8'd3, 24'hB00000, 1'b1));
    q.push_back(mk(8'd4, 24'h500000, 1'b0));
    q.push_back(mk(8'd5, 24'hC00005, 1'b1));
    q.push_back(mk(8'd6, 24'hD00006, 1'b1));
    q.push_back(mk(8'd7, 24'hF00007, 1'b1));
    q.push_back(mk(8'd8, 24'h000008, 1'b0));
    nxt(); rst_n = 1'b1;
    nxt(5); chk("t6_pc3", pcD, 3); chk("t6_br_b", isBranchD, 1);
    nxt();  chk("t6_br_add", isBranchD, 0);
    nxt(4); chk("t6_pc8", pcD, 8); chk("t6_br_nop", isBranchD, 0);
    nxt();  stallD = 1'b1;
    nxt(2);
    chk("t6_queue_drained", q.size(), 0);
    chk("t6_cnt", issuedCount, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
